pll_reset_sequencer: RTL and testbench

- Clock/reset manager that sits beside a PLL instance (SDRAM/core clock PLL) in the core top level.
- Drives the PLL reset and synchronises its asynchronous `locked` output.
- Waits for lock to hold stable, then releases NUM_CH downstream reset channels one at a time with a fixed stagger.
- On lock loss it re-asserts every channel and re-sequences. Generalises a bare PLL wrapper to N sequenced reset outputs with relock recovery.

---
 rtl/pll_seq_pkg.sv | 31 +++
 rtl/lock_sync.sv | 33 +++
 rtl/pll_reset_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_seq_pkg
// Shared definitions for the PLL reset sequencer and its helpers:
//   - seq_state_t : sequencer FSM state encoding (also exported for debug)
//   - RELOCK_CNT_W: width of the saturating lock-loss counter
//   - cnt_width() : width of a cycle counter that must reach a given terminal
//   - max2()      : elaboration-time maximum of two integers
// No ports (package).
// -----------------------------------------------------------------------------
package pll_seq_pkg;

    localparam int RELOCK_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } seq_state_t;

    // One spare bit above clog2 so the terminal value always fits.
    function automatic int cnt_width(input int max_cycles);
        return $clog2(max_cycles) + 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// -----------------------------------------------------------------------------
// lock_sync
// Multi-flop synchroniser for a slow asynchronous status level (PLL locked and
// similar). The chain clears to 0 on the asynchronous active-low reset, so the
// synchronised level reads "not locked" out of reset.
// Ports:
//   clk         in   destination clock
//   reset_n     in   asynchronous active-low clear
//   async_level in   asynchronous status input
//   sync_level  out  status after STAGES flops in the clk domain
// -----------------------------------------------------------------------------
module lock_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_level,
    output logic sync_level
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_level};
        end
    end

    assign sync_level = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
// Holds the PLL in reset, waits for a synchronised lock to stay stable, then
// releases NUM_CH active-low reset channels one at a time with a fixed
// stagger. Lock loss in RELEASE/RUN drops every channel and re-sequences
// without resetting the PLL; soft_rst forces a full sequence including a PLL
// reset.
// Optional build macro PLL_RESEQ_TIMEOUT_EN: when defined, WAIT_LOCK gives up
// after LOCK_TIMEOUT_CYCLES and retries the PLL reset, counting it as a
// lock-loss event.
// Ports:
//   clk              in   free-running reference clock
//   reset_n          in   asynchronous active-low reset
//   pll_locked_async in   PLL locked, asynchronous to clk
//   soft_rst         in   one-cycle request for a full re-sequence
//   pll_rst          out  active-high PLL reset
//   ch_rst_n         out  per-channel active-low resets (channel 0 first)
//   ready            out  all channels released and lock held
//   relock_count     out  saturating count of lock-loss events
//   seq_state        out  FSM state, for debug
// -----------------------------------------------------------------------------
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_CH              = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES      = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int SYNC_STAGES         = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pll_locked_async,
    input  logic                    soft_rst,
    output logic                    pll_rst,
    output logic [NUM_CH-1:0]       ch_rst_n,
    output logic                    ready,
    output logic [RELOCK_CNT_W-1:0] relock_count,
    output logic [2:0]              seq_state
);

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("pll_reset_sequencer: NUM_CH must be 1..8");
    end
    if (PLL_RST_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || STAGGER_CYCLES < 1
        || LOCK_TIMEOUT_CYCLES < 1) begin : g_bad_cycles
        $error("pll_reset_sequencer: cycle parameters must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("pll_reset_sequencer: SYNC_STAGES must be >= 2");
    end

    localparam int BASE_MAX = max2(max2(PLL_RST_CYCLES, LOCK_STABLE_CYCLES), STAGGER_CYCLES);
`ifdef PLL_RESEQ_TIMEOUT_EN
    localparam int MAX_CYCLES = max2(BASE_MAX, LOCK_TIMEOUT_CYCLES);
`else
    localparam int MAX_CYCLES = BASE_MAX;
`endif
    localparam int CNT_W = cnt_width(MAX_CYCLES);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    // The WAIT_LOCK cycle that first sees locked_s is itself a locked cycle,
    // so STABLE only needs LOCK_STABLE_CYCLES-1 more of them (at least one).
    localparam logic [CNT_W-1:0] STABLE_LAST  =
        CNT_W'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
`ifdef PLL_RESEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
`endif
    localparam logic [IDX_W-1:0] LAST_CH      = IDX_W'(NUM_CH - 1);

    seq_state_t        state;
    seq_state_t        state_next;
    logic              locked_s;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  ch_idx;
    logic [IDX_W-1:0]  ch_idx_nxt;
    logic              cnt_inc;
    logic              ch_first;
    logic              ch_step;
    logic              ch_drop;
    logic              loss_evt;

    lock_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .async_level (pll_locked_async),
        .sync_level  (locked_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_PLL_RST;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the datapath strobes that go with each transition.
    // Any cycle without cnt_inc clears the counter, so every state change
    // starts its new state from zero.
    always_comb begin
        state_next = state;
        cnt_inc    = 1'b0;
        ch_first   = 1'b0;
        ch_step    = 1'b0;
        ch_drop    = 1'b0;
        loss_evt   = 1'b0;
        if (soft_rst) begin
            state_next = ST_PLL_RST;
            ch_drop    = 1'b1;
        end else begin
            case (state)
                ST_PLL_RST: begin
                    if (cnt == PLL_RST_LAST) state_next = ST_WAIT_LOCK;
                    else                     cnt_inc    = 1'b1;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_next = ST_STABLE;
                    end
`ifdef PLL_RESEQ_TIMEOUT_EN
                    else if (cnt == TIMEOUT_LAST) begin
                        state_next = ST_PLL_RST;
                        loss_evt   = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
`endif
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_next = ST_WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        state_next = ST_RELEASE;
                        ch_first   = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!locked_s) begin
                        state_next = ST_WAIT_LOCK;
                        ch_drop    = 1'b1;
                        loss_evt   = 1'b1;
                    end else if (ch_idx == LAST_CH) begin
                        state_next = ST_RUN;
                    end else if (cnt == STAGGER_LAST) begin
                        ch_step = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_next = ST_WAIT_LOCK;
                        ch_drop    = 1'b1;
                        loss_evt   = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_PLL_RST;
                    ch_drop    = 1'b1;
                end
            endcase
        end
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        pll_rst   = (state == ST_PLL_RST);
        ready     = (state == ST_RUN);
        seq_state = state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    assign ch_idx_nxt = ch_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_rst_n <= '0;
            ch_idx   <= '0;
        end else if (ch_drop) begin
            ch_rst_n <= '0;
            ch_idx   <= '0;
        end else if (ch_first) begin
            ch_rst_n <= NUM_CH'(1);
            ch_idx   <= '0;
        end else if (ch_step) begin
            ch_rst_n <= ch_rst_n | (NUM_CH'(1) << ch_idx_nxt);
            ch_idx   <= ch_idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            relock_count <= '0;
        end else if (loss_evt && (relock_count != {RELOCK_CNT_W{1'b1}})) begin
            relock_count <= relock_count + RELOCK_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
// Directed bench for pll_reset_sequencer with NUM_CH=3, PLL_RST=16, STABLE=8,
// STAGGER=4, TIMEOUT=100, SYNC_STAGES=2. Inputs change 1 time unit after a
// rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int NUM_CH   = 3;
    localparam int PLL_RSTC = 16;
    localparam int STABLE   = 8;
    localparam int STAGGER  = 4;
    localparam int TIMEOUT  = 100;
    localparam int SYNC     = 2;
    // Async lock rise to ch_rst_n[0] rise.
    localparam int LOCK_LAT = SYNC + STABLE;

`ifdef PLL_RESEQ_TIMEOUT_EN
    localparam int EXP_PULSES = 4;
    localparam int EXP_HIGH   = 4 * PLL_RSTC;
    localparam int EXP_BASE   = 4;
`else
    localparam int EXP_PULSES = 1;
    localparam int EXP_HIGH   = PLL_RSTC;
    localparam int EXP_BASE   = 1;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              locked_async;
    logic              soft_rst;
    logic              pll_rst;
    logic [NUM_CH-1:0] ch_rst_n;
    logic              ready;
    logic [7:0]        relock_count;
    logic [2:0]        seq_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .NUM_CH              (NUM_CH),
        .PLL_RST_CYCLES      (PLL_RSTC),
        .LOCK_STABLE_CYCLES  (STABLE),
        .STAGGER_CYCLES      (STAGGER),
        .LOCK_TIMEOUT_CYCLES (TIMEOUT),
        .SYNC_STAGES         (SYNC)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pll_locked_async (locked_async),
        .soft_rst         (soft_rst),
        .pll_rst          (pll_rst),
        .ch_rst_n         (ch_rst_n),
        .ready            (ready),
        .relock_count     (relock_count),
        .seq_state        (seq_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; locked_async = 1'b0; soft_rst = 1'b0;
        repeat (3) tick();
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL reset_pll_rst actual=%b expected=1", pll_rst); end
        checks++; if (ch_rst_n !== 3'b000) begin failures++; $display("FAIL reset_ch_rst_n actual=%b expected=000", ch_rst_n); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready actual=%b expected=0", ready); end
        checks++; if (relock_count !== 8'd0) begin failures++; $display("FAIL reset_relock actual=%0d expected=0", relock_count); end
        checks++; if (seq_state !== 3'd0) begin failures++; $display("FAIL reset_state actual=%0d expected=0", seq_state); end
    endtask

    // From the moment lock rises with the FSM in WAIT_LOCK: checks the full
    // release staircase and the step into RUN.
    task automatic check_sequence(input string tag);
        int n;
        n = 0; do begin tick(); n++; end while (ch_rst_n[0] !== 1'b1 && n < 200);
        checks++; if (n != LOCK_LAT) begin failures++; $display("FAIL %s_ch0_latency actual=%0d expected=%0d", tag, n, LOCK_LAT); end
        checks++; if (ch_rst_n !== 3'b001 || seq_state !== 3'd3) begin failures++; $display("FAIL %s_ch0_state actual=%b/%0d expected=001/3", tag, ch_rst_n, seq_state); end
        n = 0; do begin tick(); n++; end while (ch_rst_n[1] !== 1'b1 && n < 200);
        checks++; if (n != STAGGER || ch_rst_n !== 3'b011) begin failures++; $display("FAIL %s_ch1 actual=%0d/%b expected=%0d/011", tag, n, ch_rst_n, STAGGER); end
        n = 0; do begin tick(); n++; end while (ch_rst_n[2] !== 1'b1 && n < 200);
        checks++; if (n != STAGGER || ready !== 1'b0) begin failures++; $display("FAIL %s_ch2 actual=%0d/rdy%b expected=%0d/rdy0", tag, n, ready, STAGGER); end
        tick();
        checks++; if (ready !== 1'b1 || seq_state !== 3'd4 || ch_rst_n !== 3'b111) begin failures++; $display("FAIL %s_run actual=rdy%b/%0d/%b expected=rdy1/4/111", tag, ready, seq_state, ch_rst_n); end
    endtask

    task automatic test_power_up();
        int n;
        reset_n = 1'b1;
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n != PLL_RSTC) begin failures++; $display("FAIL pwr_pll_rst_width actual=%0d expected=%0d", n, PLL_RSTC); end
        checks++; if (seq_state !== 3'd1) begin failures++; $display("FAIL pwr_wait_lock actual=%0d expected=1", seq_state); end
        repeat (5) tick();
        locked_async = 1'b1;
        check_sequence("pwr");
    endtask

    task automatic test_stable_glitch();
        int n;
        soft_rst = 1'b1; tick(); soft_rst = 1'b0;
        checks++; if (seq_state !== 3'd0 || pll_rst !== 1'b1 || ch_rst_n !== 3'b000 || ready !== 1'b0) begin failures++; $display("FAIL soft_entry actual=%0d/%b/%b/%b expected=0/1/000/0", seq_state, pll_rst, ch_rst_n, ready); end
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n != PLL_RSTC) begin failures++; $display("FAIL soft_pll_rst_width actual=%0d expected=%0d", n, PLL_RSTC); end
        repeat (3) tick();
        checks++; if (seq_state !== 3'd2) begin failures++; $display("FAIL glitch_in_stable actual=%0d expected=2", seq_state); end
        locked_async = 1'b0;
        repeat (3) tick();
        checks++; if (seq_state !== 3'd1 || ch_rst_n !== 3'b000) begin failures++; $display("FAIL glitch_back_wait actual=%0d/%b expected=1/000", seq_state, ch_rst_n); end
        locked_async = 1'b1;
        check_sequence("glitch");
        checks++; if (relock_count !== 8'd0) begin failures++; $display("FAIL glitch_relock actual=%0d expected=0", relock_count); end
    endtask

    task automatic test_lock_loss_run();
        int n;
        locked_async = 1'b0;
        n = 0; do begin tick(); n++; end while ((ch_rst_n !== 3'b000 || ready !== 1'b0) && n < 50);
        checks++; if (n != SYNC + 1) begin failures++; $display("FAIL loss_drop_latency actual=%0d expected=%0d", n, SYNC + 1); end
        checks++; if (seq_state !== 3'd1 || relock_count !== 8'd1) begin failures++; $display("FAIL loss_state actual=%0d/%0d expected=1/1", seq_state, relock_count); end
        repeat (20 - n) tick();
        locked_async = 1'b1;
        check_sequence("reseq");
    endtask

    task automatic test_soft_rst_with_loss();
        int n;
        soft_rst = 1'b1; locked_async = 1'b0;
        tick();
        soft_rst = 1'b0;
        checks++; if (seq_state !== 3'd0 || pll_rst !== 1'b1 || ch_rst_n !== 3'b000 || ready !== 1'b0) begin failures++; $display("FAIL softloss_entry actual=%0d/%b/%b/%b expected=0/1/000/0", seq_state, pll_rst, ch_rst_n, ready); end
        checks++; if (relock_count !== 8'd1) begin failures++; $display("FAIL softloss_relock actual=%0d expected=1", relock_count); end
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n != PLL_RSTC) begin failures++; $display("FAIL softloss_pll_rst_width actual=%0d expected=%0d", n, PLL_RSTC); end
        checks++; if (seq_state !== 3'd1 || relock_count !== 8'd1) begin failures++; $display("FAIL softloss_after actual=%0d/%0d expected=1/1", seq_state, relock_count); end
    endtask

    task automatic test_timeout();
        int  pulses, high;
        logic prev;
        pulses = 0; high = 0; prev = 1'b0;
        soft_rst = 1'b1; tick(); soft_rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (pll_rst === 1'b1 && prev === 1'b0) pulses++;
            if (pll_rst === 1'b1) high++;
            prev = pll_rst;
            tick();
        end
        checks++; if (pulses != EXP_PULSES) begin failures++; $display("FAIL timeout_pulses actual=%0d expected=%0d", pulses, EXP_PULSES); end
        checks++; if (high != EXP_HIGH) begin failures++; $display("FAIL timeout_high_cycles actual=%0d expected=%0d", high, EXP_HIGH); end
        checks++; if (relock_count !== 8'(EXP_BASE)) begin failures++; $display("FAIL timeout_relock actual=%0d expected=%0d", relock_count, EXP_BASE); end
    endtask

    task automatic test_relock_saturate();
        int n;
        bit stuck;
        stuck = 1'b0;
        for (int i = 0; i < 300; i++) begin
            locked_async = 1'b1;
            n = 0; do begin tick(); n++; end while (ch_rst_n[0] !== 1'b1 && n < 50);
            if (n >= 50) stuck = 1'b1;
            locked_async = 1'b0;
            n = 0; do begin tick(); n++; end while (seq_state !== 3'd1 && n < 50);
            if (n >= 50) stuck = 1'b1;
            if (i == 9) begin
                checks++; if (relock_count !== 8'(EXP_BASE + 10)) begin failures++; $display("FAIL sat_relock_10 actual=%0d expected=%0d", relock_count, EXP_BASE + 10); end
            end
        end
        checks++; if (stuck) begin failures++; $display("FAIL sat_loop_timeout actual=stuck expected=progress"); end
        checks++; if (relock_count !== 8'd255) begin failures++; $display("FAIL sat_relock actual=%0d expected=255", relock_count); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_stable_glitch();
        test_lock_loss_run();
        test_soft_rst_with_loss();
        test_timeout();
        test_relock_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
